// File: rtl/product_accumulator_pkg.sv
// Shared types and elaboration-time helpers for the product accumulator.
package product_accumulator_pkg;

  // Frame state: IDLE means no beat of the current frame has been seen yet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Legal parameter combination: result at least as wide as a product,
  // and a beat counter of at least one bit.
  function automatic bit widths_ok(input int width_in, input int width_acc,
                                   input int count_width);
    return (width_acc >= width_in) && (count_width >= 1);
  endfunction

endpackage

// File: rtl/product_accumulator_acc_add_sat.sv
// Extended add with overflow detect for the product accumulator.
// Optional clamping on overflow when PRODUCT_ACCUMULATOR_SAT_EN is defined;
// otherwise the sum wraps and ovf still reports the wrap.
module product_accumulator_acc_add_sat
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH_ACC = 80
) (
  input  logic [WIDTH_ACC-1:0] acc,
  input  logic [WIDTH_ACC-1:0] ext,
  input  logic                 is_signed,
  output logic [WIDTH_ACC-1:0] sum,
  output logic                 ovf
);

  logic [WIDTH_ACC:0] sum_wide_s;

  // One-bit-wider add, interpreted as signed or unsigned per the current beat.
  always_comb begin
    sum_wide_s = '0;
    ovf        = 1'b0;
    if (is_signed) begin
      sum_wide_s = {acc[WIDTH_ACC-1], acc} + {ext[WIDTH_ACC-1], ext};
      ovf        = sum_wide_s[WIDTH_ACC] ^ sum_wide_s[WIDTH_ACC-1];
    end else begin
      sum_wide_s = {1'b0, acc} + {1'b0, ext};
      ovf        = sum_wide_s[WIDTH_ACC];
    end
  end

  // Result select: wrapped sum, or clamp toward the true sign on overflow.
  always_comb begin
    sum = sum_wide_s[WIDTH_ACC-1:0];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    if (ovf) begin
      if (is_signed) begin
        // The extra bit carries the true sign of the exact sum.
        if (sum_wide_s[WIDTH_ACC]) begin
          sum = {1'b1, {(WIDTH_ACC-1){1'b0}}};
        end else begin
          sum = {1'b0, {(WIDTH_ACC-1){1'b1}}};
        end
      end else begin
        sum = {WIDTH_ACC{1'b1}};
      end
    end else begin
      sum = sum_wide_s[WIDTH_ACC-1:0];
    end
`else
    sum = sum_wide_s[WIDTH_ACC-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator behind the pipelined multiplier. Sums each framed stream
// of products and presents the frame result on a valid/ready output. Never
// stalls its input: a result that finds the output register occupied is
// dropped and recorded in the sticky overrun flag.
// Optional build macro: PRODUCT_ACCUMULATOR_SAT_EN (saturate instead of wrap).
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH_IN    = 64,
  parameter int WIDTH_ACC   = 80,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_signed,
  input  logic                   in_valid,
  input  logic [WIDTH_IN-1:0]    in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH_ACC-1:0]   out_sum,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_ovf,
  output logic                   overrun,
  input  logic                   clr_overrun
);

  if (!widths_ok(WIDTH_IN, WIDTH_ACC, COUNT_WIDTH)) begin : g_bad_widths
    $error("product_accumulator: need WIDTH_ACC >= WIDTH_IN and COUNT_WIDTH >= 1");
  end

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [WIDTH_ACC-1:0]   acc_r;
  logic [WIDTH_ACC-1:0]   acc_nxt_s;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic [COUNT_WIDTH-1:0] cnt_nxt_s;
  logic                   fovf_r;
  logic                   fovf_nxt_s;

  logic [WIDTH_ACC-1:0]   ext_s;
  logic [WIDTH_ACC-1:0]   add_base_s;
  logic [WIDTH_ACC-1:0]   add_sum_s;
  logic                   add_ovf_s;
  logic [COUNT_WIDTH-1:0] beat_cnt_s;
  logic                   frame_ovf_s;
  logic                   done_s;
  logic                   out_free_s;

  // Widen the product: sign- or zero-extension chosen per beat.
  always_comb begin
    if (is_signed) begin
      ext_s = WIDTH_ACC'($signed(in_data));
    end else begin
      ext_s = WIDTH_ACC'(in_data);
    end
  end

  // First beat of a frame adds to zero, so IDLE and ACC share one adder.
  always_comb begin
    if (state_r == ACC) begin
      add_base_s = acc_r;
    end else begin
      add_base_s = '0;
    end
  end

  product_accumulator_acc_add_sat #(
    .WIDTH_ACC (WIDTH_ACC)
  ) u_add (
    .acc       (add_base_s),
    .ext       (ext_s),
    .is_signed (is_signed),
    .sum       (add_sum_s),
    .ovf       (add_ovf_s)
  );

  // Beat count including this beat (saturating) and frame-sticky overflow.
  always_comb begin
    if (state_r == IDLE) begin
      beat_cnt_s  = COUNT_WIDTH'(1);
      frame_ovf_s = add_ovf_s;
    end else begin
      if (&cnt_r) begin
        beat_cnt_s = cnt_r;
      end else begin
        beat_cnt_s = cnt_r + COUNT_WIDTH'(1);
      end
      frame_ovf_s = fovf_r | add_ovf_s;
    end
  end

  // Next-state and frame datapath decode.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    fovf_nxt_s  = fovf_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE, ACC: begin
        if (in_valid) begin
          if (in_last) begin
            state_nxt_s = IDLE;
            acc_nxt_s   = '0;
            cnt_nxt_s   = '0;
            fovf_nxt_s  = 1'b0;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = ACC;
            acc_nxt_s   = add_sum_s;
            cnt_nxt_s   = beat_cnt_s;
            fovf_nxt_s  = frame_ovf_s;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        acc_nxt_s   = '0;
        cnt_nxt_s   = '0;
        fovf_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output register can take a result if empty or being drained this cycle.
  always_comb begin
    out_free_s = ~out_valid | out_ready;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Running accumulator, beat counter and per-frame overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= '0;
      cnt_r  <= '0;
      fovf_r <= 1'b0;
    end else begin
      acc_r  <= acc_nxt_s;
      cnt_r  <= cnt_nxt_s;
      fovf_r <= fovf_nxt_s;
    end
  end

  // Result register: load on completion when free, clear on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (done_s && out_free_s) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum_s;
      out_count <= beat_cnt_s;
      out_ovf   <= frame_ovf_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Sticky overrun: a dropped result sets it, and setting beats clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (done_s && !out_free_s) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a 12-bit-accumulator instance
// and an 8-bit (WIDTH_ACC == WIDTH_IN) instance share one input stream.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       is_signed = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic        out_valid12, out_ovf12, overrun12;
  logic [11:0] out_sum12;
  logic [2:0]  out_count12;
  logic        out_valid8, out_ovf8, overrun8;
  logic [7:0]  out_sum8;
  logic [2:0]  out_count8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.WIDTH_IN(8), .WIDTH_ACC(12), .COUNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .is_signed(is_signed), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid12),
    .out_ready(out_ready), .out_sum(out_sum12), .out_count(out_count12),
    .out_ovf(out_ovf12), .overrun(overrun12), .clr_overrun(clr_overrun)
  );

  product_accumulator #(.WIDTH_IN(8), .WIDTH_ACC(8), .COUNT_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .is_signed(is_signed), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .out_sum(out_sum8), .out_count(out_count8),
    .out_ovf(out_ovf8), .overrun(overrun8), .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic [11:0] sum12;
    logic [7:0]  sum8;
    logic [2:0]  cnt;
    logic        ovf12;
    logic        ovf8;
  } sb_t;

  sb_t sb_q[$];

  // reference model state
  longint m_acc12, m_acc8;
  bit     m_fovf12, m_fovf8, m_in_frame, m_valid, m_ovr;
  int     m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // exact arithmetic on a w-bit accumulator; acc kept as unsigned w-bit pattern
  function automatic void model_add(input int w, input longint acc_in, input bit sgn,
                                    input logic [7:0] d, output longint acc_out,
                                    output bit ov);
    longint mask, a, e, t, lo, hi;
    mask = (longint'(1) << w) - 1;
    a = acc_in & mask;
    if (sgn) begin
      e = longint'($signed(d));
      if (a[w-1]) a = a - (longint'(1) << w);
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
    end else begin
      e  = longint'(d);
      lo = 0;
      hi = mask;
    end
    t  = a + e;
    ov = (t < lo) || (t > hi);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    if (t > hi) t = hi;
    if (t < lo) t = lo;
`endif
    acc_out = t & mask;
  endfunction

  task automatic model_reset();
    m_acc12 = 0; m_acc8 = 0; m_fovf12 = 0; m_fovf8 = 0;
    m_in_frame = 0; m_valid = 0; m_ovr = 0; m_cnt = 0;
    sb_q.delete();
  endtask

  // compare the DUT output against the scoreboard just before the edge
  task automatic sample();
    sb_t r;
    check("out_valid", out_valid12, m_valid);
    check("out_valid8", out_valid8, m_valid);
    check("overrun", overrun12, m_ovr);
    if (out_valid12 && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 0, 1);
      end else begin
        r = sb_q.pop_front();
        check("out_sum", out_sum12, r.sum12);
        check("out_count", out_count12, r.cnt);
        check("out_ovf", out_ovf12, r.ovf12);
        check("out_sum8", out_sum8, r.sum8);
        check("out_ovf8", out_ovf8, r.ovf8);
      end
    end
  endtask

  // advance the reference model across the coming edge
  task automatic model_edge();
    longint b12, b8, n12, n8;
    bit     o12, o8, f12, f8, done, set;
    int     c;
    sb_t    r;
    done = 0;
    set  = 0;
    if (in_valid) begin
      b12 = m_in_frame ? m_acc12 : 0;
      b8  = m_in_frame ? m_acc8 : 0;
      model_add(12, b12, is_signed, in_data, n12, o12);
      model_add(8, b8, is_signed, in_data, n8, o8);
      f12 = (m_in_frame && m_fovf12) || o12;
      f8  = (m_in_frame && m_fovf8) || o8;
      c   = m_in_frame ? ((m_cnt == 7) ? 7 : m_cnt + 1) : 1;
      if (in_last) begin
        done = 1;
        r.sum12 = n12[11:0]; r.sum8 = n8[7:0]; r.cnt = c[2:0];
        r.ovf12 = f12; r.ovf8 = f8;
        m_in_frame = 0; m_acc12 = 0; m_acc8 = 0; m_cnt = 0;
        m_fovf12 = 0; m_fovf8 = 0;
      end else begin
        m_in_frame = 1; m_acc12 = n12; m_acc8 = n8; m_cnt = c;
        m_fovf12 = f12; m_fovf8 = f8;
      end
    end
    if (done && (!m_valid || out_ready)) begin
      sb_q.push_back(r);
      m_valid = 1;
    end else if (done) begin
      set = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (set) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
  endtask

  task automatic drive(input bit v, input bit l, input bit s, input bit rd,
                       input bit cl, input logic [7:0] d);
    in_valid = v; in_last = l; is_signed = s; out_ready = rd;
    clr_overrun = cl; in_data = d;
    @(negedge clk);
    sample();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", out_valid12, 0);
    check("rst_sum", out_sum12, 0);
    check("rst_count", out_count12, 0);
    check("rst_ovf", out_ovf12, 0);
    check("rst_overrun", overrun12, 0);
    check("rst_sum8", out_sum8, 0);
  endtask

  typedef struct {
    logic       v, l, s, rdy, clr;
    logic [7:0] d;
    logic       exp_valid;
    logic [11:0] exp_sum;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    //           v     l     s     rdy   clr   data    valid sum       ovr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3,   1'b0, 12'd0,    1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5,   1'b0, 12'd0,    1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd7,   1'b1, 12'd15,   1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFE,  1'b0, 12'd0,    1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd10,  1'b0, 12'd0,    1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hEC,  1'b1, 12'hFF4,  1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 12'd0,    1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd200, 1'b0, 12'd0,    1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd100, 1'b1, 12'd300,  1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1,   1'b1, 12'd1,    1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2,   1'b1, 12'd2,    1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3,   1'b1, 12'd3,    1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4,   1'b1, 12'd4,    1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 12'd0,    1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1,   1'b1, 12'd1,    1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 12'd1,    1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 12'd0,    1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 12'd0,    1'b0};

    model_reset();
    @(posedge clk);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].s, tbl[i].rdy, tbl[i].clr, tbl[i].d);
      check($sformatf("tbl%0d_valid", i), out_valid12, tbl[i].exp_valid);
      check($sformatf("tbl%0d_overrun", i), overrun12, tbl[i].exp_ovr);
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_sum", i), out_sum12, tbl[i].exp_sum);
    end

    // reset in the middle of a frame loses the partial sum
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd9);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd9);
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    check("rstmid_sum", out_sum12, 12'd4);
    check("rstmid_count", out_count12, 3'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // beat counter saturates at all-ones over a ten-beat frame
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    check("sat_count", out_count12, 3'd7);
    check("sat_count_sum", out_sum12, 12'd10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // signed overflow on the narrow instance: 100 + 100
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd100);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd100);
    check("sovf_flag8", out_ovf8, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // a drop coinciding with clr_overrun leaves overrun set
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd6);
    check("setwins_overrun", overrun12, 1'b1);
    check("setwins_hold", out_sum12, 12'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
